// File: rtl/dmac_ahbl_regs.sv
// AHB-Lite slave register file for the DMA master engine: descriptor registers,
// start pulse generation, sticky DONE/ERR status and a registered CPU interrupt.
module dmac_ahbl_regs #(
    parameter int AW = 8
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic [31:0] saddr,
    output logic [31:0] daddr,
    output logic [31:0] icra,
    output logic [31:0] icrv,
    output logic [2:0]  ssize,
    output logic [2:0]  dsize,
    output logic [2:0]  sinc,
    output logic [2:0]  dinc,
    output logic [2:0]  irqsrc,
    output logic [15:0] bsize,
    output logic [7:0]  bcount,
    output logic        wfi,
    output logic        start,
    input  logic        dma_done,
    input  logic        dma_busy,
    output logic        irq
);

    localparam int IW = AW - 2;
    localparam logic [IW-1:0] IDX_SADDR  = IW'(0);
    localparam logic [IW-1:0] IDX_DADDR  = IW'(1);
    localparam logic [IW-1:0] IDX_CFG    = IW'(2);
    localparam logic [IW-1:0] IDX_BSIZE  = IW'(3);
    localparam logic [IW-1:0] IDX_BCOUNT = IW'(4);
    localparam logic [IW-1:0] IDX_ICRA   = IW'(5);
    localparam logic [IW-1:0] IDX_ICRV   = IW'(6);
    localparam logic [IW-1:0] IDX_CTRL   = IW'(7);
    localparam logic [IW-1:0] IDX_STATUS = IW'(8);
    localparam logic [IW-1:0] IDX_IM     = IW'(9);
    localparam logic [31:0]   CFG_MASK   = 32'h0071_7777;
    localparam logic [31:0]   CFG_RESET  = 32'h0000_4422;

    logic          dph_valid_q;
    logic          dph_write_q;
    logic [IW-1:0] dph_idx_q;

    logic [31:0] saddr_q, daddr_q, cfg_q, icra_q, icrv_q;
    logic [15:0] bsize_q;
    logic [7:0]  bcount_q;
    logic [1:0]  im_q;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        pend_q, pend_d;
    logic        start_q, start_d;
    logic        irq_q, irq_d;

    logic        accept;
    logic        wr_en;
    logic        busy;
    logic        lock_hit;
    logic        reg_wr;
    logic        status_wr;
    logic [31:0] rdata;
    logic        unused_ok;

    assign accept = HSEL & HTRANS[1] & HREADY;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dph_valid_q <= 1'b0;
            dph_write_q <= 1'b0;
            dph_idx_q   <= '0;
        end else begin
            dph_valid_q <= accept;
            if (accept) begin
                dph_write_q <= HWRITE;
                dph_idx_q   <= HADDR[AW-1:2];
            end
        end
    end

    // Descriptor and control registers (0x00-0x1C) are frozen while the engine is busy.
    assign wr_en     = dph_valid_q & dph_write_q;
    assign busy      = dma_busy | start_q | pend_q;
    assign lock_hit  = wr_en & busy & (dph_idx_q <= IDX_CTRL);
    assign reg_wr    = wr_en & ~lock_hit;
    assign status_wr = reg_wr & (dph_idx_q == IDX_STATUS);

    always_comb begin
        start_d = reg_wr & (dph_idx_q == IDX_CTRL) & HWDATA[0];
        pend_d  = pend_q;
        if (start_d)
            pend_d = 1'b1;
        else if (dma_busy)
            pend_d = 1'b0;
        // Hardware set beats a simultaneous software clear.
        done_d = dma_done | (done_q & ~(status_wr & HWDATA[1]));
        err_d  = lock_hit | (err_q & ~(status_wr & HWDATA[2]));
        irq_d  = (done_q & im_q[0]) | (err_q & im_q[1]);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            saddr_q  <= '0;
            daddr_q  <= '0;
            cfg_q    <= CFG_RESET;
            bsize_q  <= '0;
            bcount_q <= '0;
            icra_q   <= '0;
            icrv_q   <= '0;
            im_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            pend_q   <= 1'b0;
            start_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            done_q  <= done_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            start_q <= start_d;
            irq_q   <= irq_d;
            if (reg_wr) begin
                case (dph_idx_q)
                    IDX_SADDR:  saddr_q  <= HWDATA;
                    IDX_DADDR:  daddr_q  <= HWDATA;
                    IDX_CFG:    cfg_q    <= HWDATA & CFG_MASK;
                    IDX_BSIZE:  bsize_q  <= HWDATA[15:0];
                    IDX_BCOUNT: bcount_q <= HWDATA[7:0];
                    IDX_ICRA:   icra_q   <= HWDATA;
                    IDX_ICRV:   icrv_q   <= HWDATA;
                    IDX_IM:     im_q     <= HWDATA[1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (dph_valid_q & ~dph_write_q) begin
            case (dph_idx_q)
                IDX_SADDR:  rdata = saddr_q;
                IDX_DADDR:  rdata = daddr_q;
                IDX_CFG:    rdata = cfg_q;
                IDX_BSIZE:  rdata = {16'h0, bsize_q};
                IDX_BCOUNT: rdata = {24'h0, bcount_q};
                IDX_ICRA:   rdata = icra_q;
                IDX_ICRV:   rdata = icrv_q;
                IDX_STATUS: rdata = {29'h0, err_q, done_q, busy};
                IDX_IM:     rdata = {30'h0, im_q};
                default:    rdata = '0;
            endcase
        end
    end

    assign HRDATA    = rdata;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    assign saddr  = saddr_q;
    assign daddr  = daddr_q;
    assign icra   = icra_q;
    assign icrv   = icrv_q;
    assign bsize  = bsize_q;
    assign bcount = bcount_q;
    assign ssize  = cfg_q[2:0];
    assign dsize  = cfg_q[6:4];
    assign sinc   = cfg_q[10:8];
    assign dinc   = cfg_q[14:12];
    assign wfi    = cfg_q[16];
    assign irqsrc = cfg_q[22:20];
    assign start  = start_q;
    assign irq    = irq_q;

    assign unused_ok = ^{HSIZE, HTRANS[0], HADDR[31:AW], HADDR[1:0], cfg_q[31:23],
                         cfg_q[19:17], cfg_q[15], cfg_q[11], cfg_q[7], cfg_q[3]};

endmodule

// File: tb/tb_dmac_ahbl_regs.sv
// Directed bench for dmac_ahbl_regs: table of bus reads/writes plus hand-built
// sequences for start, busy lock, sticky status, interrupt and reset corners.
module tb_dmac_ahbl_regs;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic [31:0] saddr, daddr, icra, icrv;
    logic [2:0]  ssize, dsize, sinc, dinc, irqsrc;
    logic [15:0] bsize;
    logic [7:0]  bcount;
    logic        wfi, start, dma_done, dma_busy, irq;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) if (start === 1'b1) start_cnt <= start_cnt + 1;

    dmac_ahbl_regs #(.AW(8)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY),
        .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .saddr(saddr), .daddr(daddr), .icra(icra), .icrv(icrv),
        .ssize(ssize), .dsize(dsize), .sinc(sinc), .dinc(dinc), .irqsrc(irqsrc),
        .bsize(bsize), .bcount(bcount), .wfi(wfi), .start(start),
        .dma_done(dma_done), .dma_busy(dma_busy), .irq(irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end else begin
            $display("ok   %s act=%h", name, act);
        end
    endtask

    task automatic add(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
        vec_t v;
        v.wr = w; v.addr = a; v.data = d; v.exp = e;
        vecs.push_back(v);
    endtask

    // Called at a negedge; returns at the negedge after the data phase completed.
    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        @(negedge HCLK);
        HWDATA = d; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        @(negedge HCLK);
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int base;

        HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'b010; HREADY = 1'b1; HWDATA = '0; dma_done = 1'b0; dma_busy = 1'b0;
        repeat (3) @(negedge HCLK);
        check("rst_start", {31'h0, start}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_hrdata", HRDATA, 32'h0);
        check("hreadyout", {31'h0, HREADYOUT}, 32'h1);
        check("hresp", {31'h0, HRESP}, 32'h0);
        HRESETn = 1'b1;
        @(negedge HCLK);

        // Reset values of every offset, then writes, masks and read-back.
        add(0, 32'h00, 0, 32'h0);
        add(0, 32'h04, 0, 32'h0);
        add(0, 32'h08, 0, 32'h0000_4422);
        add(0, 32'h0C, 0, 32'h0);
        add(0, 32'h10, 0, 32'h0);
        add(0, 32'h14, 0, 32'h0);
        add(0, 32'h18, 0, 32'h0);
        add(0, 32'h1C, 0, 32'h0);
        add(0, 32'h20, 0, 32'h0);
        add(0, 32'h24, 0, 32'h0);
        add(0, 32'h28, 0, 32'h0);
        add(1, 32'h00, 32'h2000_0000, 0);
        add(1, 32'h0C, 32'hABCD_000F, 0);
        add(0, 32'h00, 0, 32'h2000_0000);
        add(0, 32'h0C, 0, 32'h0000_000F);
        add(1, 32'h10, 32'h0000_01FF, 0);
        add(0, 32'h10, 0, 32'h0000_00FF);
        add(1, 32'h08, 32'hFFFF_FFFF, 0);
        add(0, 32'h08, 0, 32'h0071_7777);
        add(1, 32'h08, 32'h0000_4422, 0);
        add(0, 32'h08, 0, 32'h0000_4422);
        add(1, 32'h14, 32'hCAFE_0001, 0);
        add(0, 32'h14, 0, 32'hCAFE_0001);
        add(1, 32'h18, 32'h0000_BEEF, 0);
        add(0, 32'h18, 0, 32'h0000_BEEF);
        add(1, 32'h28, 32'hFFFF_FFFF, 0);
        add(0, 32'h28, 0, 32'h0);
        add(0, 32'h4000_0000, 0, 32'h2000_0000);
        add(0, 32'hFC, 0, 32'h0);
        add(1, 32'h24, 32'hFFFF_FFFF, 0);
        add(0, 32'h24, 0, 32'h0000_0003);
        add(1, 32'h24, 32'h0, 0);
        add(0, 32'h24, 0, 32'h0);

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                ahb_write(vecs[i].addr, vecs[i].data);
            end else begin
                ahb_read(vecs[i].addr, rd);
                check($sformatf("vec%0d_rd_%h", i, vecs[i].addr), rd, vecs[i].exp);
            end
        end
        check("saddr_out", saddr, 32'h2000_0000);
        check("bsize_out", {16'h0, bsize}, 32'h0000_000F);
        check("ssize_out", {29'h0, ssize}, 32'h2);
        check("dinc_out", {29'h0, dinc}, 32'h4);

        // Start pulse: exactly one cycle, second CTRL write is locked out.
        base = start_cnt;
        ahb_write(32'h1C, 32'h1);
        check("start_hi", {31'h0, start}, 32'h1);
        @(negedge HCLK);
        check("start_lo", {31'h0, start}, 32'h0);
        ahb_write(32'h1C, 32'h1);
        @(negedge HCLK);
        check("start_count", start_cnt - base, 32'h1);
        ahb_read(32'h20, rd);
        check("status_pend_err", rd, 32'h5);
        dma_busy = 1'b1;
        repeat (2) @(negedge HCLK);
        dma_busy = 1'b0;
        @(negedge HCLK);
        ahb_read(32'h20, rd);
        check("status_idle_err", rd, 32'h4);
        ahb_write(32'h20, 32'h4);
        ahb_read(32'h20, rd);
        check("status_err_clr", rd, 32'h0);

        // DONE sticky and registered irq.
        ahb_write(32'h24, 32'h1);
        dma_done = 1'b1;
        @(negedge HCLK);
        dma_done = 1'b0;
        check("irq_lag", {31'h0, irq}, 32'h0);
        @(negedge HCLK);
        check("irq_set", {31'h0, irq}, 32'h1);
        ahb_read(32'h20, rd);
        check("status_done", rd, 32'h2);
        ahb_write(32'h20, 32'h2);
        ahb_read(32'h20, rd);
        check("status_done_clr", rd, 32'h0);
        check("irq_clr", {31'h0, irq}, 32'h0);

        // Busy lock on descriptor writes; set wins over W1C.
        dma_busy = 1'b1;
        ahb_write(32'h04, 32'h0000_1234);
        check("daddr_locked", daddr, 32'h0);
        ahb_read(32'h04, rd);
        check("daddr_rd_locked", rd, 32'h0);
        dma_done = 1'b1;
        @(negedge HCLK);
        dma_done = 1'b0;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h20;
        @(negedge HCLK);
        HWDATA = 32'h2; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; dma_done = 1'b1;
        @(negedge HCLK);
        dma_done = 1'b0;
        ahb_read(32'h20, rd);
        check("status_set_wins", rd, 32'h7);
        dma_busy = 1'b0;
        ahb_write(32'h20, 32'h6);
        ahb_read(32'h20, rd);
        check("status_all_clr", rd, 32'h0);

        // IDLE transfer and stalled address phase must not write.
        HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b1; HADDR = 32'h00;
        @(negedge HCLK);
        HWDATA = 32'hDEAD_BEEF; HSEL = 1'b0; HWRITE = 1'b0;
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h00; HREADY = 1'b0;
        @(negedge HCLK);
        HREADY = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h0BAD_0BAD;
        @(negedge HCLK);
        ahb_read(32'h00, rd);
        check("no_write_idle_stall", rd, 32'h2000_0000);

        // Reset in the middle of a start.
        ahb_write(32'h1C, 32'h1);
        check("start_before_rst", {31'h0, start}, 32'h1);
        HRESETn = 1'b0;
        #1;
        check("rst_mid_start", {31'h0, start}, 32'h0);
        check("rst_mid_saddr", saddr, 32'h0);
        check("rst_mid_sinc", {29'h0, sinc}, 32'h4);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        ahb_read(32'h20, rd);
        check("rst_mid_status", rd, 32'h0);
        ahb_read(32'h08, rd);
        check("rst_mid_cfg", rd, 32'h0000_4422);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
